// File: rtl/sipo_pkg.sv
// sipo_pkg: bit-order constants and counter sizing shared by the deserializer
package sipo_pkg;
  localparam logic DIR_MSB_FIRST = 1'b0;
  localparam logic DIR_LSB_FIRST = 1'b1;
  function automatic int cnt_w(input int width);
    return $clog2(width);
  endfunction
endpackage

// File: rtl/sipo_deser_if.sv
// sipo_deser_if: serial stream controls and word valid/ready handshake
interface sipo_deser_if #(parameter int WIDTH = 32);
  import sipo_pkg::*;
  logic en;
  logic serial_in;
  logic sync;
  logic lsb_first;
  logic ovr_clr;
  logic ready;
  logic [WIDTH-1:0] data;
  logic valid;
  logic overrun;
  logic [cnt_w(WIDTH)-1:0] bit_cnt;
  modport master (
    output en, serial_in, sync, lsb_first, ovr_clr, ready,
    input data, valid, overrun, bit_cnt
  );
  modport slave (
    input en, serial_in, sync, lsb_first, ovr_clr, ready,
    output data, valid, overrun, bit_cnt
  );
endinterface

// File: rtl/sipo_shift_core.sv
// sipo_shift_core: shift register, bit counter, per-word order latch and resync
module sipo_shift_core import sipo_pkg::*; #(
  parameter int WIDTH = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic serial_in,
  input  logic sync,
  input  logic lsb_first,
  output logic [WIDTH-1:0] word,
  output logic word_done,
  output logic [cnt_w(WIDTH)-1:0] bit_cnt
);
  localparam int CW = cnt_w(WIDTH);
  logic [WIDTH-1:0] sh, base;
  logic [CW-1:0] cnt0;
  logic mode, m;
  always_comb begin
    base = sync ? '0 : sh;
    cnt0 = sync ? '0 : bit_cnt;
    m = cnt0 == '0 ? lsb_first : mode;
    word = m == DIR_LSB_FIRST ? {serial_in, base[WIDTH-1:1]} : {base[WIDTH-2:0], serial_in};
    word_done = en && !sync && bit_cnt == CW'(WIDTH - 1);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sh <= '0;
      bit_cnt <= '0;
      mode <= DIR_MSB_FIRST;
    end else if (en) begin
      sh <= word;
      bit_cnt <= word_done ? '0 : cnt0 + CW'(1);
      mode <= m;
    end else if (sync) begin
      sh <= '0;
      bit_cnt <= '0;
    end
endmodule

// File: rtl/sipo_deser.sv
// sipo_deser: serial-to-parallel deserializer with holding register, handshake and overrun flag
module sipo_deser import sipo_pkg::*; #(
  parameter int WIDTH = 32
) (
  input logic clk,
  input logic rst,
  sipo_deser_if.slave bus
);
  logic [WIDTH-1:0] word;
  logic [cnt_w(WIDTH)-1:0] cnt;
  logic done, free;
  sipo_shift_core #(.WIDTH(WIDTH)) u_core (
    .clk(clk),
    .rst(rst),
    .en(bus.en),
    .serial_in(bus.serial_in),
    .sync(bus.sync),
    .lsb_first(bus.lsb_first),
    .word(word),
    .word_done(done),
    .bit_cnt(cnt)
  );
  assign bus.bit_cnt = cnt;
  assign free = !bus.valid || bus.ready;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      bus.data <= '0;
      bus.valid <= 1'b0;
      bus.overrun <= 1'b0;
    end else begin
      bus.data <= done && free ? word : bus.data;
      bus.valid <= done || (bus.valid && !bus.ready);
      bus.overrun <= (done && !free) || (bus.overrun && !bus.ovr_clr);
    end
endmodule

// File: tb/tb_sipo_deser.sv
// tb_sipo_deser: directed plus randomized scoreboard bench for sipo_deser at WIDTH=8
module tb_sipo_deser;
  localparam int W = 8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  sipo_deser_if #(.WIDTH(W)) bus();
  sipo_deser #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];
  bit bits[$];
  bit m_mode = 1'b0;
  bit m_valid = 1'b0;
  bit m_ovr = 1'b0;
  task automatic chk(input string n, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask
  always @(negedge clk)
    if (!rst && bus.valid && bus.ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL word: got %0h expected no word", bus.data);
      end else chk("word", bus.data, exp_q.pop_front());
    end
  task automatic cyc(input logic e, input logic b, input logic s, input logic l, input logic r, input logic c);
    bit comp, drop;
    logic [W-1:0] w;
    comp = 1'b0;
    drop = 1'b0;
    w = '0;
    bus.en = e;
    bus.serial_in = b;
    bus.sync = s;
    bus.lsb_first = l;
    bus.ready = r;
    bus.ovr_clr = c;
    if (s) bits.delete();
    if (e) begin
      if (bits.size() == 0) m_mode = l;
      bits.push_back(b);
    end
    if (bits.size() == W) begin
      foreach (bits[i]) w[m_mode ? i : W - 1 - i] = bits[i];
      bits.delete();
      comp = 1'b1;
    end
    if (comp) begin
      if (m_valid && !r) drop = 1'b1;
      else begin
        exp_q.push_back(w);
        m_valid = 1'b1;
      end
    end else if (r) m_valid = 1'b0;
    if (drop) m_ovr = 1'b1;
    else if (c) m_ovr = 1'b0;
    @(posedge clk);
    #1;
    chk("valid", bus.valid, m_valid);
    chk("overrun", bus.overrun, m_ovr);
    chk("bit_cnt", bus.bit_cnt, bits.size());
  endtask
  task automatic send(input logic [W-1:0] v, input logic l, input logic tog, input logic r_last);
    for (int i = 0; i < W; i++)
      cyc(1'b1, v[W-1-i], 1'b0, tog ? l ^ i[0] : l, i == W - 1 ? r_last : 1'b0, 1'b0);
  endtask
  task automatic consume();
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask
  initial begin
    {bus.en, bus.serial_in, bus.sync, bus.lsb_first, bus.ready, bus.ovr_clr} = '0;
    #12;
    chk("rst_data", bus.data, 0);
    chk("rst_valid", bus.valid, 0);
    chk("rst_overrun", bus.overrun, 0);
    chk("rst_bit_cnt", bus.bit_cnt, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    send(8'hB2, 1'b0, 1'b0, 1'b0);
    chk("msb_data", bus.data, 8'hB2);
    consume();
    send(8'hB2, 1'b1, 1'b1, 1'b0);
    chk("lsb_data", bus.data, 8'h4D);
    consume();
    send(8'hB2, 1'b0, 1'b0, 1'b0);
    send(8'hFF, 1'b0, 1'b0, 1'b0);
    chk("ovr_data", bus.data, 8'hB2);
    chk("ovr_flag", bus.overrun, 1);
    consume();
    chk("ovr_consume_valid", bus.valid, 0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("ovr_clr", bus.overrun, 0);
    send(8'h11, 1'b0, 1'b0, 1'b0);
    send(8'h3C, 1'b0, 1'b0, 1'b1);
    chk("simul_data", bus.data, 8'h3C);
    chk("simul_valid", bus.valid, 1);
    chk("simul_overrun", bus.overrun, 0);
    consume();
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'($urandom), 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) cyc(1'b1, i == 6, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("sync_data", bus.data, 8'h81);
    consume();
    send(8'h5A, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'($urandom), 1'b0, 1'b0, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    bits.delete();
    exp_q.delete();
    m_valid = 1'b0;
    m_ovr = 1'b0;
    m_mode = 1'b0;
    #1;
    chk("async_rst_data", bus.data, 0);
    chk("async_rst_valid", bus.valid, 0);
    chk("async_rst_bit_cnt", bus.bit_cnt, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    send(8'hC3, 1'b0, 1'b0, 1'b0);
    chk("post_rst_data", bus.data, 8'hC3);
    consume();
    repeat (3000)
      cyc($urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 39) == 0, 1'($urandom),
          $urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0);
    repeat (2) consume();
    chk("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/sipo_deser.md
# sipo_deser

Parametrised serial-to-parallel deserializer, the successor to the fixed 32-bit shift register. It assembles WIDTH-bit words from a strobed serial stream, with per-word MSB-first/LSB-first selection and resynchronisation. Each completed word goes to a holding register behind a valid/ready handshake, and overrun is detected. It sits between the serial receive front end and word-level consumers (FIFO, register file).

## Interface
- WIDTH, 32: word length in bits; legal range 2..64.
- clk  in  1  clock, rising-edge.
- rst  in  1  reset, asynchronous, active-high.
- en  in  1  bit strobe; serial_in is sampled on edges where en=1.
- serial_in  in  1  serial data bit.
- sync  in  1  word realign; aborts the partial word and restarts at bit 0.
- lsb_first  in  1  bit order for the next word (0 = MSB-first, 1 = LSB-first).
- ovr_clr  in  1  clears the sticky overrun flag.
- data  out  WIDTH  assembled word (holding register).
- valid  out  1  data holds an unconsumed word.
- ready  in  1  consumer accepts data when valid=1.
- overrun  out  1  sticky; a completed word was dropped.
- bit_cnt  out  $clog2(WIDTH)  bits already captured in the current word.

## Operation
- Reset values: shift register 0, bit_cnt 0, mode 0, data 0, valid 0, overrun 0.
- **Mode latch.** Order is taken from lsb_first on the edge capturing bit 0 (en=1, bit_cnt=0). It is held for the whole word, so mid-word lsb_first changes are ignored.
- **MSB-first shift.** sh <= {sh[WIDTH-2:0], serial_in}. The first bit received ends in data[WIDTH-1].
- **LSB-first shift.** sh <= {serial_in, sh[WIDTH-1:1]}. The first bit received ends in data[0]; this is the legacy bit placement.
- **Bit counter.** bit_cnt increments on each en and wraps WIDTH-1 -> 0 on the completing bit.
- **Word completion** (en=1, bit_cnt=WIDTH-1), on the same edge:
  - if the holding register is free (valid=0, or valid=1 and ready=1): data <= the fully shifted word and valid <= 1;
  - otherwise the word is dropped, data and valid are unchanged, and overrun <= 1.
- **Consume.** valid=1 and ready=1 with no completion on that edge: valid <= 0 and data keeps its value.
- **Simultaneous consume and completion.** The new word is loaded and valid stays 1. This is not an overrun.
- **sync=1.** bit_cnt <= 0 and the shift register is cleared.
  - If en=1 on the same edge, serial_in becomes bit 0 of the new word and the mode is latched; bit_cnt <= 1.
  - sync has priority over completion: a word is never completed on a sync edge.
  - sync does not touch data, valid or overrun.
- **Overrun flag.** ovr_clr=1 clears overrun. If a drop happens on the same edge as ovr_clr, overrun stays 1 (set wins).
- **ready with valid=0** is ignored.
- **Reset mid-word.** Immediately discards the partial word and any pending output.

## Timing
- Single clock domain. All outputs are registered; there are no combinational paths from inputs to outputs.
- Latency: data and valid update on the same edge that samples the last bit, so they are visible in the cycle after that edge.
- Throughput: one word per WIDTH strobes; en may be held high continuously.
- Back-to-back words need no gap cycle.
- The consumer has the full WIDTH strobes to assert ready before an overrun occurs.

## Structure
- Package sipo_pkg:
  - constant DIR_MSB_FIRST=1'b0 and DIR_LSB_FIRST=1'b1;
  - function cnt_w(WIDTH) returning $clog2(WIDTH).
- Sub-module sipo_shift_core:
  - contains the shift register, bit counter, mode latch and sync handling;
  - outputs the next-word value and a word_done pulse.
- Top level sipo_deser contains the holding register, the valid/ready logic and the overrun flag.

## Test plan
All scenarios use WIDTH=8.
- **MSB-first:** lsb_first=0, en held high, bits 1,0,1,1,0,0,1,0 -> data=0xB2 and valid=1 one cycle after the 8th bit; bit_cnt returns to 0.
- **LSB-first:** same bit sequence with lsb_first=1 -> data=0x4D; toggling lsb_first mid-word has no effect.
- **Overrun:**
  - ready=0, two words 0xB2 then 0xFF -> data stays 0xB2, overrun=1;
  - ready=1 for one cycle -> valid=0;
  - ovr_clr -> overrun=0.
- **Simultaneous consume and completion:** ready=1 on the edge completing the second word 0x3C -> data=0x3C, valid stays 1, overrun=0.
- **sync mid-word:** after 5 bits assert sync with en=1 and bit=1, then send 7 more bits 0,0,0,0,0,0,1 (MSB-first) -> data=0x81; the earlier partial word never appears.
- **Reset:** assert rst asynchronously at bit_cnt=4 with valid=1 -> all outputs 0 immediately; the next 8 bits form a clean word.
